// File: rtl/decoupler.sv
// Width-halving stream splitter: 2*P_WIDTH-bit words in, P_WIDTH-bit elements out,
// low half first; a zero low half terminates the pair and its high half is discarded.
module decoupler #(
    parameter int P_WIDTH = 128
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2*P_WIDTH-1:0]   i_data,
    input  logic                   i_enq,
    output logic                   o_full,
    output logic [P_WIDTH-1:0]     o_data,
    input  logic                   i_deq,
    output logic                   o_empty
);

    localparam logic [4:0] DEPTH = 5'd16;

    typedef enum logic {
        S_LOW,
        S_HIGH
    } state_t;

    state_t               r_state;

    logic [2*P_WIDTH-1:0] r_in_mem [16];
    logic [3:0]           r_in_wr;
    logic [3:0]           r_in_rd;
    logic [4:0]           r_in_cnt;

    logic [P_WIDTH-1:0]   r_out_mem [16];
    logic [3:0]           r_out_wr;
    logic [3:0]           r_out_rd;
    logic [4:0]           r_out_cnt;

    logic [2*P_WIDTH-1:0] w_head;
    logic [P_WIDTH-1:0]   w_lo;
    logic [P_WIDTH-1:0]   w_hi;
    logic [P_WIDTH-1:0]   w_elem;
    logic                 w_in_push;
    logic                 w_in_pop;
    logic                 w_out_push;
    logic                 w_out_pop;
    logic                 w_split;

    always_comb begin
        w_head     = r_in_mem[r_in_rd];
        w_lo       = w_head[P_WIDTH-1:0];
        w_hi       = w_head[2*P_WIDTH-1:P_WIDTH];
        // Enqueue acceptance looks only at the registered count, so a word
        // offered while full is dropped even if the splitter pops this cycle.
        w_in_push  = i_enq && (r_in_cnt != DEPTH);
        w_split    = (r_in_cnt != '0) && (r_out_cnt != DEPTH);
        w_out_push = w_split;
        w_out_pop  = i_deq && (r_out_cnt != '0);
        w_elem     = (r_state == S_HIGH) ? w_hi : w_lo;
        w_in_pop   = w_split && ((r_state == S_HIGH) || (w_lo == '0));
    end

    always_ff @(posedge i_clk) begin
        if (w_in_push && !i_rst) begin
            r_in_mem[r_in_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_out_push && !i_rst) begin
            r_out_mem[r_out_wr] <= w_elem;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_wr  <= '0;
            r_in_rd  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wr <= r_in_wr + 4'd1;
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + 4'd1;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 5'd1;
                2'b01:   r_in_cnt <= r_in_cnt - 5'd1;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wr <= r_out_wr + 4'd1;
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + 4'd1;
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 5'd1;
                2'b01:   r_out_cnt <= r_out_cnt - 5'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_LOW;
        end else if (w_split) begin
            case (r_state)
                S_LOW:   r_state <= (w_lo == '0) ? S_LOW : S_HIGH;
                S_HIGH:  r_state <= S_LOW;
                default: r_state <= S_LOW;
            endcase
        end
    end

    assign o_full  = (r_in_cnt == DEPTH);
    assign o_empty = (r_out_cnt == '0);
    assign o_data  = (r_out_cnt == '0) ? '0 : r_out_mem[r_out_rd];

endmodule
